// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register.
//   state_t        : stage occupancy state, encoded so that it doubles as
//                    the occupancy count (EMPTY=0, MAIN=1, BOTH=2).
//   REG_ADDR_W     : default register-file address width.
//   stage_entry_t  : one held entry at default widths {rfen, a3, data}.
//   entry_w()      : packed width of an entry for given data/address widths.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DEF_DATA_W = 96;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_BOTH  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  rfen;
    logic [REG_ADDR_W-1:0] a3;
    logic [DEF_DATA_W-1:0] data;
  } stage_entry_t;

  function automatic int entry_w(input int data_w, input int addr_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Single entry register with asynchronous active-low reset, synchronous
// clear and load. Clear wins over load so a flushed slot always reads 0.
// Ports:
//   clk, reset : clock, async active-low reset
//   clear      : synchronous clear to 0
//   load       : capture d at the next edge
//   d, q       : entry in / held entry out
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register carrying {payload, rfen, a3} under a
// valid/ready handshake, with flush and an optional skid entry.
//
// Handshake: an entry moves across a boundary on a cycle where valid and
// ready are both high at the rising edge (Accept upstream, Consume
// downstream); valid, once raised, is held with stable fields until that
// edge.
//
// Ports:
//   clk, reset                 : clock, async active-low reset
//   flush                      : drop all held entries at the next edge
//   in_valid/in_ready          : upstream handshake
//   in_data/in_rfen/in_a3      : upstream entry
//   out_valid/out_ready        : downstream handshake
//   out_data/out_rfen/out_a3   : presented entry (rfen qualified)
//   occupancy                  : held entries, equal to the FSM state code
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W           = 96,
  parameter int ADDR_W           = REG_ADDR_W,
  parameter int SKID             = 1,
  parameter int ZERO_A3_SUPPRESS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_rfen,
  input  logic [ADDR_W-1:0] in_a3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_rfen,
  output logic [ADDR_W-1:0] out_a3,
  output logic [1:0]        occupancy
);

  localparam int EW = entry_w(DATA_W, ADDR_W);

  typedef struct packed {
    logic              rfen;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t state, nxt;
  entry_t in_entry, main_d, main_q, skid_q;
  logic   accept, consume;
  logic   main_load, main_clear, skid_load, skid_clear;

  assign in_entry  = '{rfen: in_rfen, a3: in_a3, data: in_data};
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= nxt;
  end

  // Flush overrides everything; a Consume in the same cycle has already
  // been sampled downstream, so clearing the entry is still correct.
  always_comb begin
    nxt        = state;
    main_d     = in_entry;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      nxt        = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            nxt       = ST_MAIN;
            main_load = 1'b1;
          end
        end
        ST_MAIN: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            nxt       = ST_BOTH;
            skid_load = 1'b1;
          end else if (consume) begin
            nxt        = ST_EMPTY;
            main_clear = 1'b1;
          end
        end
        ST_BOTH: begin
          // in_ready is low here, so only a Consume can happen.
          if (consume) begin
            nxt        = ST_MAIN;
            main_d     = skid_q;
            main_load  = 1'b1;
            skid_clear = 1'b1;
          end
        end
        default: nxt = ST_EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(.W(EW)) u_main (
    .clk   (clk),
    .reset (reset),
    .clear (main_clear),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  if (SKID != 0) begin : g_skid
    logic ready_q;

    pipe_entry_reg #(.W(EW)) u_skid (
      .clk   (clk),
      .reset (reset),
      .clear (skid_clear),
      .load  (skid_load),
      .d     (in_entry),
      .q     (skid_q)
    );

    // Ready comes from a flop so it never depends on out_ready; flush
    // still gates it so the flush-cycle offer is refused.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) ready_q <= 1'b1;
      else        ready_q <= (nxt != ST_BOTH);
    end

    assign in_ready = ready_q & ~flush;
  end else begin : g_noskid
    logic unused_skid_ctl;
    assign unused_skid_ctl = skid_load | skid_clear;
    assign skid_q          = '0;
    assign in_ready        = (~out_valid | out_ready) & ~flush;
  end

  assign out_data  = main_q.data;
  assign out_a3    = main_q.a3;
  assign out_rfen  = main_q.rfen & out_valid &
                     ((ZERO_A3_SUPPRESS != 0) ? (main_q.a3 != '0) : 1'b1);
  assign occupancy = 2'(state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table for the SKID=1 build
// plus hand-written sequences for streaming, async reset and SKID=0.
module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int AW = 5;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance signals
  logic          flush, in_valid, in_ready, in_rfen, out_valid, out_ready, out_rfen;
  logic [DW-1:0] in_data, out_data;
  logic [AW-1:0] in_a3, out_a3;
  logic [1:0]    occupancy;

  // SKID=0 instance signals
  logic          z_flush, z_in_valid, z_in_ready, z_in_rfen, z_out_valid, z_out_ready, z_out_rfen;
  logic [DW-1:0] z_in_data, z_out_data;
  logic [AW-1:0] z_in_a3, z_out_a3;
  logic [1:0]    z_occupancy;

  pipe_stage_reg #(.DATA_W(DW), .ADDR_W(AW), .SKID(1), .ZERO_A3_SUPPRESS(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rfen(in_rfen), .in_a3(in_a3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rfen(out_rfen), .out_a3(out_a3), .occupancy(occupancy)
  );

  pipe_stage_reg #(.DATA_W(DW), .ADDR_W(AW), .SKID(0), .ZERO_A3_SUPPRESS(1)) dut0 (
    .clk(clk), .reset(reset), .flush(z_flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .in_rfen(z_in_rfen), .in_a3(z_in_a3),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
    .out_rfen(z_out_rfen), .out_a3(z_out_a3), .occupancy(z_occupancy)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // vector table: inputs applied for one cycle, in_ready checked before
  // the edge, outputs checked after it
  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          rf;
    logic [AW-1:0] a3;
    logic          ordy;
    logic          fl;
    logic          e_rdy;
    logic          e_ov;
    logic [DW-1:0] e_d;
    logic          e_rf;
    logic [AW-1:0] e_a3;
    logic [1:0]    e_occ;
  } vec_t;

  localparam int NV = 21;
  vec_t vt[NV];

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic rf,
                              input logic [AW-1:0] a3, input logic ordy, input logic fl,
                              input logic e_rdy, input logic e_ov, input logic [DW-1:0] e_d,
                              input logic e_rf, input logic [AW-1:0] e_a3, input logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.d = d; v.rf = rf; v.a3 = a3; v.ordy = ordy; v.fl = fl;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_d = e_d; v.e_rf = e_rf; v.e_a3 = e_a3; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic rf,
                       input logic [AW-1:0] a3, input logic ordy, input logic fl);
    in_valid = iv; in_data = d; in_rfen = rf; in_a3 = a3; out_ready = ordy; flush = fl;
  endtask

  task automatic run_vec(input int k);
    string tag;
    tag = $sformatf("v%0d", k);
    drive(vt[k].iv, vt[k].d, vt[k].rf, vt[k].a3, vt[k].ordy, vt[k].fl);
    #1;
    chk({tag, ".in_ready"}, DW'(in_ready), DW'(vt[k].e_rdy));
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(vt[k].e_ov));
    chk({tag, ".out_data"},  out_data,       vt[k].e_d);
    chk({tag, ".out_rfen"},  DW'(out_rfen),  DW'(vt[k].e_rf));
    chk({tag, ".out_a3"},    DW'(out_a3),    DW'(vt[k].e_a3));
    chk({tag, ".occupancy"}, DW'(occupancy), DW'(vt[k].e_occ));
  endtask

  initial begin
    //           iv  data    rf a3  ordy fl | rdy ov  out_data rf a3  occ
    vt[0]  = mk(1, 'h1234, 1, 8,  1, 0,   1, 1, 'h1234, 1, 8,  1); // single entry
    vt[1]  = mk(0, 'h0,    0, 0,  1, 0,   1, 0, 'h0,    0, 0,  0);
    vt[2]  = mk(1, 'hA,    1, 3,  0, 0,   1, 1, 'hA,    1, 3,  1); // A held
    vt[3]  = mk(1, 'hB,    0, 4,  0, 0,   1, 1, 'hA,    1, 3,  2); // B into skid
    vt[4]  = mk(1, 'hD,    1, 5,  0, 0,   0, 1, 'hA,    1, 3,  2); // full: D refused
    vt[5]  = mk(0, 'h0,    0, 0,  1, 0,   0, 1, 'hB,    0, 4,  1); // A out, B to main
    vt[6]  = mk(0, 'h0,    0, 0,  1, 0,   1, 0, 'h0,    0, 0,  0); // B out
    vt[7]  = mk(1, 'h11,   1, 1,  0, 0,   1, 1, 'h11,   1, 1,  1);
    vt[8]  = mk(1, 'h22,   1, 2,  0, 0,   1, 1, 'h11,   1, 1,  2);
    vt[9]  = mk(1, 'hC,    1, 6,  0, 1,   0, 0, 'h0,    0, 0,  0); // flush, C refused
    vt[10] = mk(0, 'h0,    0, 0,  1, 0,   1, 0, 'h0,    0, 0,  0); // C never appears
    vt[11] = mk(1, 'h55,   1, 0,  1, 0,   1, 1, 'h55,   0, 0,  1); // a3=0 suppresses rfen
    vt[12] = mk(0, 'h0,    0, 0,  1, 0,   1, 0, 'h0,    0, 0,  0);
    vt[13] = mk(1, 'h66,   1, 7,  0, 0,   1, 1, 'h66,   1, 7,  1);
    vt[14] = mk(0, 'h0,    0, 0,  1, 1,   0, 0, 'h0,    0, 0,  0); // consume + flush
    vt[15] = mk(1, 'h77,   1, 9,  1, 0,   1, 1, 'h77,   1, 9,  1);
    vt[16] = mk(1, 'h78,   0, 10, 1, 0,   1, 1, 'h78,   0, 10, 1); // replace in MAIN
    vt[17] = mk(0, 'h0,    0, 0,  1, 0,   1, 0, 'h0,    0, 0,  0);
    vt[18] = mk(1, 'h99,   1, 11, 0, 0,   1, 1, 'h99,   1, 11, 1); // stall
    vt[19] = mk(0, 'h0,    0, 0,  0, 0,   1, 1, 'h99,   1, 11, 1); // held stable
    vt[20] = mk(0, 'h0,    0, 0,  1, 0,   1, 0, 'h0,    0, 0,  0);

    drive(0, '0, 0, '0, 0, 0);
    z_flush = 0; z_in_valid = 0; z_in_data = '0; z_in_rfen = 0; z_in_a3 = '0; z_out_ready = 0;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", DW'(out_valid), '0);
    chk("rst.out_data",  out_data,       '0);
    chk("rst.occupancy", DW'(occupancy), '0);
    reset = 1'b1;
    #1;
    chk("rst.in_ready",  DW'(in_ready),  DW'(1'b1));
    chk("rst.out_rfen",  DW'(out_rfen),  '0);
    chk("rst.out_a3",    DW'(out_a3),    '0);

    for (int k = 0; k < NV; k++) run_vec(k);

    // streaming: 16 back-to-back entries, one-cycle latency, no gaps
    for (int i = 0; i < 16; i++) begin
      drive(1, DW'(i), 1, AW'(i + 1), 1, 0);
      #1;
      chk($sformatf("stream%0d.in_ready", i), DW'(in_ready), DW'(1'b1));
      @(posedge clk); #1;
      chk($sformatf("stream%0d.out_valid", i), DW'(out_valid), DW'(1'b1));
      chk($sformatf("stream%0d.out_data", i),  out_data,       DW'(i));
    end
    drive(0, '0, 0, '0, 1, 0);
    @(posedge clk); #1;
    chk("stream.drain.out_valid", DW'(out_valid), '0);

    // async reset mid-cycle drops a held entry without a clock edge
    drive(1, 'h42, 1, 1, 0, 0);
    @(posedge clk); #1;
    chk("areset.pre.out_valid", DW'(out_valid), DW'(1'b1));
    drive(0, '0, 0, '0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("areset.out_valid", DW'(out_valid), '0);
    chk("areset.out_data",  out_data,       '0);
    chk("areset.occupancy", DW'(occupancy), '0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("areset.rel.in_ready", DW'(in_ready), DW'(1'b1));

    // SKID=0: combinational ready, replace on same-cycle consume
    z_in_valid = 1; z_in_data = 'h10; z_in_rfen = 1; z_in_a3 = 2; z_out_ready = 0;
    #1;
    chk("s0.empty.in_ready", DW'(z_in_ready), DW'(1'b1));
    @(posedge clk); #1;
    chk("s0.e.out_valid", DW'(z_out_valid), DW'(1'b1));
    chk("s0.e.out_data",  z_out_data,       'h10);
    chk("s0.e.occupancy", DW'(z_occupancy), DW'(2'd1));
    z_in_data = 'h20; z_in_a3 = 3;
    #1;
    chk("s0.stall.in_ready", DW'(z_in_ready), '0);
    z_out_ready = 1;
    #1;
    chk("s0.comb.in_ready", DW'(z_in_ready), DW'(1'b1));
    @(posedge clk); #1;
    chk("s0.f.out_data",  z_out_data,       'h20);
    chk("s0.f.out_a3",    DW'(z_out_a3),    DW'(5'd3));
    chk("s0.f.occupancy", DW'(z_occupancy), DW'(2'd1));
    z_in_valid = 0;
    @(posedge clk); #1;
    chk("s0.drain.out_valid", DW'(z_out_valid), '0);
    chk("s0.drain.occupancy", DW'(z_occupancy), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register that replaces the fixed per-stage latches between pipeline stages (D/E, E/M, M/W).
- Carries an arbitrary payload, plus the register-file write enable and destination address, under a valid/ready handshake.
- Supports stall (backpressure), flush (bubble insertion) and an optional skid entry, so that the ready path is fully registered.
- Forwarding and hazard logic read the out_* register-write fields directly.

Parameters:
- DATA_W, 96: payload width in bits (for example ALU result, memory read data and PC+8 concatenated).
- ADDR_W, 5: destination register address width.
- SKID, 1: 1 adds a second (skid) entry and makes in_ready a pure register output; 0 uses a single entry with combinational in_ready.
- ZERO_A3_SUPPRESS, 1: 1 forces out_rfen low when out_a3 is 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards every held entry at the next edge.
- in_valid  input  1  upstream entry is offered.
- in_ready  output  1  stage accepts an entry this cycle.
- in_data  input  DATA_W  upstream payload.
- in_rfen  input  1  upstream register-file write enable.
- in_a3  input  ADDR_W  upstream destination register.
- out_valid  output  1  an entry is presented downstream.
- out_ready  input  1  downstream consumes the entry this cycle.
- out_data  output  DATA_W  presented payload.
- out_rfen  output  1  qualified write enable.
- out_a3  output  ADDR_W  presented destination register.
- occupancy  output  2  number of held entries (0..2; at most 1 when SKID=0).

Behaviour:
- Handshake terms:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
  - Payload, rfen and a3 always travel together as one entry.
- Reset (reset low, asynchronous):
  - Both entries are emptied and all stored fields cleared to 0.
  - Outputs: out_valid=0, out_data=0, out_rfen=0, out_a3=0, occupancy=0.
  - in_ready=1 once reset is released.
- Reset asserted mid-transfer drops the entry. No partial entry survives.
- Output qualification:
  - out_rfen = main_rfen & out_valid & (ZERO_A3_SUPPRESS ? out_a3!=0 : 1).
  - out_data and out_a3 show the main entry. They read 0 when the stage is empty, because empty entries are cleared.
- SKID=1 state machine (states: EMPTY, MAIN, BOTH):
  - EMPTY: on Accept, go to MAIN; the entry appears on out_* next cycle (latency 1).
  - MAIN:
    - Accept & Consume: stay in MAIN; the new entry replaces the old.
    - Accept & !Consume: go to BOTH; the new entry goes to the skid register.
    - !Accept & Consume: go to EMPTY.
  - BOTH:
    - Consume: skid moves to main; go to MAIN.
    - No Accept is possible in this state.
  - in_ready = (state != BOTH), registered. It is never a combinational function of out_ready.
- SKID=0 (single entry):
  - in_ready = !out_valid | out_ready (combinational).
  - Accept loads main. Consume without Accept empties main.
- Flush:
  - Flush has priority over every other event.
  - At the edge it forces the EMPTY state and clears all fields.
  - in_ready is forced low while flush=1, so an input offered in the flush cycle is not accepted and upstream must re-offer it.
  - A Consume coincident with flush still completes, since downstream sampled that entry in the same cycle.
- Ordering: entries leave strictly in arrival order. No entry is duplicated or dropped except by flush or reset.
- Stall: out_ready=0 with a held entry holds all out_* values stable every cycle. This is the legacy "stall" behaviour.
- occupancy encoding: EMPTY=0, MAIN=1, BOTH=2.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding (ST_EMPTY, ST_MAIN, ST_BOTH, 2-bit);
  - the default widths (REG_ADDR_W=5);
  - a packed entry struct builder macro/typedef stage_entry_t {rfen, a3, data}.
- One sub-module is natural: pipe_entry_reg, a single clearable, loadable entry register with async active-low clear. It is instantiated once for main and once for skid (the skid instance only under SKID=1).

Test Plan:
- Reset and single entry: reset low, then high. Drive in_valid=1, data=0x1234, a3=8, rfen=1, out_ready=1. Expect out_valid=1, out_data=0x1234, out_rfen=1 one cycle later, and occupancy=1.
- Backpressure into skid (SKID=1): hold out_ready=0 and offer entries A, then B.
  - After B: occupancy=2, in_ready=0, out_data=A.
  - Raise out_ready: A, then B, appear on consecutive cycles, then occupancy=0.
- Streaming: out_ready=1 constantly, 16 back-to-back entries 0..15. Expect in_ready=1 throughout, outputs 0..15 with 1-cycle latency, and no gaps.
- Flush: load 2 entries with out_ready=0, then pulse flush while in_valid=1 offers C.
  - Expect in_ready=0 in that cycle.
  - Next cycle: out_valid=0, occupancy=0, and C never appears.
- Zero register and async reset:
  - Send a3=0, rfen=1: expect out_valid=1, out_rfen=0.
  - Drop reset mid-cycle: out_valid=0 immediately, without waiting for a clock edge.
- SKID=0 build: out_ready=0 with an entry held gives in_ready=0. Setting out_ready=1 in the same cycle gives in_ready=1 combinationally, and the new entry replaces the old one at the next edge.
